// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder/subtractor.
// Purpose: holds the lookahead group size and the operand-width legality rule.
// Latency: n/a (no logic). Backpressure: n/a.
package cla_pkg;

  // Bits per carry-lookahead group; the group cell is hand-written for exactly this size.
  localparam int GROUP = 4;

  // Operand width limits.
  localparam int WIDTH_MIN = 8;
  localparam int WIDTH_MAX = 64;

  // A width is usable when it splits into whole groups and sits inside the supported range.
  function automatic bit width_is_legal(input int width);
    return ((width % GROUP) == 0) && (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/cla_group_4bit.sv
// One 4-bit carry-lookahead group, split into a front half and a back half.
// Purpose: front half forms bit and group propagate/generate; back half forms the sum from a group carry.
// Latency: purely combinational. Backpressure: none (no state, no handshake).
module cla_group_4bit
  import cla_pkg::*;
(
  // Front half: operands entering stage 1
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  output logic [GROUP-1:0] p,
  output logic [GROUP-1:0] g,
  output logic             grp_p,
  output logic             grp_g,
  // Back half: values held in stage 1 plus the lookahead carry into this group
  input  logic [GROUP-1:0] s1_a,
  input  logic [GROUP-1:0] s1_b,
  input  logic [GROUP-1:0] s1_p,
  input  logic [GROUP-1:0] s1_g,
  input  logic             group_carry,
  output logic [GROUP-1:0] sum
);

  logic [GROUP-1:0] c;

  // Bit propagate/generate and flattened group propagate/generate for the lookahead unit
  always_comb begin
    p     = a ^ b;
    g     = a & b;
    grp_p = &p;
    grp_g = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
  end

  // Intra-group carries flattened from the group carry, then the sum bits
  always_comb begin
    c[0] = group_carry;
    c[1] = s1_g[0]
         | (s1_p[0] & group_carry);
    c[2] = s1_g[1]
         | (s1_p[1] & s1_g[0])
         | (s1_p[1] & s1_p[0] & group_carry);
    c[3] = s1_g[2]
         | (s1_p[2] & s1_g[1])
         | (s1_p[2] & s1_p[1] & s1_g[0])
         | (s1_p[2] & s1_p[1] & s1_p[0] & group_carry);
    sum  = s1_a ^ s1_b ^ c;
  end

  // The top bit's propagate/generate only matter for the group carry-out, which the
  // lookahead unit derives from grp_p/grp_g instead.
  logic unused_top_pg;
  assign unused_top_pg = s1_p[3] ^ s1_g[3];

endmodule

// File: rtl/cla_pipelined_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Purpose: result = A+B+carry_in, or A-B in sub mode, plus carry-out, signed overflow and zero flags.
// Latency: 2 cycles from input acceptance to out_valid; one op per cycle while out_ready is high.
// Backpressure: a stalled output holds S2, then S1; in_ready drops only when both stages are full.
module cla_pipelined_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NGROUP = WIDTH / GROUP;

  // Refuse to elaborate with a width the group structure cannot cover.
  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("cla_pipelined_addsub: WIDTH must be a multiple of 4 between 8 and 64");
  end

  // Stage 1 holds the conditioned operands and every propagate/generate term.
  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              c0;
    logic [WIDTH-1:0]  p;
    logic [WIDTH-1:0]  g;
    logic [NGROUP-1:0] grp_p;
    logic [NGROUP-1:0] grp_g;
  } s1_t;

  // Stage 2 holds the lookahead carries alongside the visible result and flags.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic [NGROUP:0]  grp_c;
  } s2_t;

  logic              s1_valid;
  logic              s2_valid;
  logic              s1_adv;
  logic              s2_adv;
  logic              accept;
  s1_t               s1;
  s1_t               s1_next;
  s2_t               s2;
  s2_t               s2_next;

  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [WIDTH-1:0]  p_vec;
  logic [WIDTH-1:0]  g_vec;
  logic [NGROUP-1:0] gp_vec;
  logic [NGROUP-1:0] gg_vec;
  logic [NGROUP:0]   grp_c;
  logic [WIDTH-1:0]  sum_vec;
  logic              c_msb;

  // Subtraction is A + ~B + 1, so carry_in is replaced by a forced 1 in sub mode.
  always_comb begin
    b_eff = sub ? ~in_1 : in_1;
    c0    = sub | carry_in;
  end

  // Advance rules: a stage moves when it is empty or the stage after it moves.
  // Reset keeps in_ready high and hides S2 so no handshake completes while it is asserted.
  always_comb begin
    s2_adv    = !s2_valid || out_ready;
    s1_adv    = !s1_valid || s2_adv;
    in_ready  = s1_adv || reset;
    out_valid = s2_valid && !reset;
    accept    = in_valid && s1_adv;
  end

  // Group cells: front half feeds S1, back half turns S1 contents plus lookahead carries into the sum.
  for (genvar gi = 0; gi < NGROUP; gi++) begin : g_group
    cla_group_4bit u_group (
      .a           (in_0[gi*GROUP +: GROUP]),
      .b           (b_eff[gi*GROUP +: GROUP]),
      .p           (p_vec[gi*GROUP +: GROUP]),
      .g           (g_vec[gi*GROUP +: GROUP]),
      .grp_p       (gp_vec[gi]),
      .grp_g       (gg_vec[gi]),
      .s1_a        (s1.a[gi*GROUP +: GROUP]),
      .s1_b        (s1.b[gi*GROUP +: GROUP]),
      .s1_p        (s1.p[gi*GROUP +: GROUP]),
      .s1_g        (s1.g[gi*GROUP +: GROUP]),
      .group_carry (grp_c[gi]),
      .sum         (sum_vec[gi*GROUP +: GROUP])
    );
  end

  // Carry into group n as a flat sum of products over the group P/G terms:
  // C[n] = G[n-1] | P[n-1]G[n-2] | ... | P[n-1]..P[0]c0. No term uses another group's carry.
  function automatic logic lookahead(input logic [NGROUP-1:0] gp,
                                     input logic [NGROUP-1:0] gg,
                                     input logic              cin0,
                                     input int                n);
    logic carry;
    logic chain;
    carry = 1'b0;
    for (int j = 0; j < NGROUP; j++) begin
      if (j < n) begin
        chain = gg[j];
        for (int k = j + 1; k < NGROUP; k++) begin
          if (k < n) chain = chain & gp[k];
        end
        carry = carry | chain;
      end
    end
    chain = cin0;
    for (int k = 0; k < NGROUP; k++) begin
      if (k < n) chain = chain & gp[k];
    end
    return carry | chain;
  endfunction

  // Lookahead carry unit: one independent flattened term per group boundary.
  for (genvar ci = 0; ci <= NGROUP; ci++) begin : g_lookahead
    assign grp_c[ci] = lookahead(s1.grp_p, s1.grp_g, s1.c0, ci);
  end

  // Stage 1 load image straight from the input side.
  always_comb begin
    s1_next = '{
      a:     in_0,
      b:     b_eff,
      c0:    c0,
      p:     p_vec,
      g:     g_vec,
      grp_p: gp_vec,
      grp_g: gg_vec
    };
  end

  // Stage 2 load image: the carry into the MSB is recovered from the MSB sum bit,
  // and signed overflow is that carry XOR the carry out of the MSB.
  always_comb begin
    c_msb             = s1.a[WIDTH-1] ^ s1.b[WIDTH-1] ^ sum_vec[WIDTH-1];
    s2_next           = '0;
    s2_next.result    = sum_vec;
    s2_next.carry_out = grp_c[NGROUP];
    s2_next.overflow  = c_msb ^ grp_c[NGROUP];
    s2_next.zero      = (sum_vec == '0);
    s2_next.grp_c     = grp_c;
  end

  // Pipeline registers: reset wins over any handshake; each stage's data moves only with a valid op.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (accept) s1 <= s1_next;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) s2 <= s2_next;
    end
  end

  // Outputs come straight from the S2 register, so they are stable while stalled.
  always_comb begin
    result    = s2.result;
    carry_out = s2.carry_out;
    overflow  = s2.overflow;
    zero      = s2.zero;
  end

  // Registered group carries are kept as a probe point next to the result.
  logic unused_grp_c;
  assign unused_grp_c = ^s2.grp_c;

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Self-checking bench for cla_pipelined_addsub at WIDTH=16.
// Directed vector table with exact latency checks, hand-written stall and reset sequences,
// then scoreboarded random streaming against an arithmetic reference model.
module tb_cla_pipelined_addsub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_0;
  logic [W-1:0] in_1;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  cla_pipelined_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_0      (in_0),
    .in_1      (in_1),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    exp_t         e;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   sb_en = 1'b0;
  exp_t sbq[$];
  int   out_cnt = 0;
  int   last_out_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic; signed overflow from the true signed result's range,
  // subtract carry as "no borrow", i.e. A >= B unsigned.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic s);
    exp_t e;
    int ua, ub, sa, sb, ci, total, t;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    ci = cin;
    if (s) begin
      e.res = 16'(ua - ub);
      e.co  = (ua >= ub);
      t     = sa - sb;
    end else begin
      total = ua + ub + ci;
      e.res = 16'(total);
      e.co  = (total > 65535);
      t     = sa + sb + ci;
    end
    e.ov = (t > 32767) || (t < -32768);
    e.z  = (e.res == 16'h0000);
    return e;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: expected values queued on input transfers, compared in order on output transfers.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        sbq.delete();
      end else if (sb_en) begin
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got an output 0x%0h, expected none (cycle %0d)", result, cyc);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("sb_result", result, e.res);
            check("sb_carry_out", carry_out, e.co);
            check("sb_overflow", overflow, e.ov);
            check("sb_zero", zero, e.z);
          end
          out_cnt++;
          last_out_cyc = cyc;
        end
        if (in_valid && in_ready) sbq.push_back(model(in_0, in_1, carry_in, sub));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run did not complete, %0d checks made", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Present one op (called just after a rising edge) and hold it until accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
    int k;
    in_0     = a;
    in_1     = b;
    carry_in = cin;
    sub      = s;
    in_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    if (k == 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 for 200 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single op with out_ready held high: nothing after one cycle, result after exactly two.
  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_0      = v.a;
    in_1      = v.b;
    carry_in  = v.cin;
    sub       = v.sub;
    in_valid  = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_0     = 16'($urandom);
    in_1     = 16'($urandom);
    @(negedge clk);
    check({tag, "_valid_cycle1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid_cycle2"}, out_valid, 1);
    check({tag, "_result"}, result, v.e.res);
    check({tag, "_carry_out"}, carry_out, v.e.co);
    check({tag, "_overflow"}, overflow, v.e.ov);
    check({tag, "_zero"}, zero, v.e.z);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check({tag, "_drained"}, sbq.size(), 0);
  endtask

  initial begin
    vec_t         vecs[10];
    logic [W-1:0] bp_a[4];
    logic [W-1:0] bp_b[4];
    logic         bp_s[4];
    exp_t         e0;
    int           base, stalls, c0, acc, guard;
    bit           pend;

    vecs[0] = '{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0, e:'{res:16'h0000, co:1'b1, ov:1'b0, z:1'b1}};
    vecs[1] = '{a:16'h7FFF, b:16'h0001, cin:1'b0, sub:1'b0, e:'{res:16'h8000, co:1'b0, ov:1'b1, z:1'b0}};
    vecs[2] = '{a:16'h0005, b:16'h0007, cin:1'b1, sub:1'b1, e:'{res:16'hFFFE, co:1'b0, ov:1'b0, z:1'b0}};
    vecs[3] = '{a:16'h8000, b:16'h0001, cin:1'b0, sub:1'b1, e:'{res:16'h7FFF, co:1'b1, ov:1'b1, z:1'b0}};
    vecs[4] = '{a:16'h1234, b:16'h4321, cin:1'b1, sub:1'b0, e:'{res:16'h5556, co:1'b0, ov:1'b0, z:1'b0}};
    vecs[5] = '{a:16'h0000, b:16'h0000, cin:1'b0, sub:1'b1, e:'{res:16'h0000, co:1'b1, ov:1'b0, z:1'b1}};
    vecs[6] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b1, sub:1'b0, e:'{res:16'hFFFF, co:1'b1, ov:1'b0, z:1'b0}};
    vecs[7] = '{a:16'h8000, b:16'h8000, cin:1'b0, sub:1'b0, e:'{res:16'h0000, co:1'b1, ov:1'b1, z:1'b1}};
    vecs[8] = '{a:16'h0005, b:16'h0007, cin:1'b0, sub:1'b1, e:'{res:16'hFFFE, co:1'b0, ov:1'b0, z:1'b0}};
    vecs[9] = '{a:16'h0FFF, b:16'h0000, cin:1'b1, sub:1'b0, e:'{res:16'h1000, co:1'b0, ov:1'b0, z:1'b0}};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_0      = '0;
    in_1      = '0;
    carry_in  = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry_out", carry_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_zero", zero, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Directed vectors
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: two ops fill both stages while the consumer stalls
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = pick_operand();
      bp_b[i] = pick_operand();
      bp_s[i] = 1'($urandom_range(0, 1));
    end
    e0 = model(bp_a[0], bp_b[0], 1'b0, bp_s[0]);
    @(posedge clk);
    #1;
    sb_en     = 1'b1;
    base      = out_cnt;
    out_ready = 1'b0;
    send(bp_a[0], bp_b[0], 1'b0, bp_s[0]);
    send(bp_a[1], bp_b[1], 1'b0, bp_s[1]);
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_hold_result0", result, e0.res);
    repeat (2) @(negedge clk);
    check("bp_in_ready_still_full", in_ready, 0);
    check("bp_hold_result1", result, e0.res);
    check("bp_hold_carry_out", carry_out, e0.co);
    check("bp_hold_overflow", overflow, e0.ov);
    check("bp_hold_zero", zero, e0.z);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(bp_a[2], bp_b[2], 1'b0, bp_s[2]);
    send(bp_a[3], bp_b[3], 1'b0, bp_s[3]);
    drain("bp");
    check("bp_out_count", out_cnt - base, 4);

    // Reset one cycle after acceptance: the op is discarded and nothing stale appears
    @(posedge clk);
    #1;
    base = out_cnt;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_after_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("midrst_no_stale%0d", k), out_valid, 0);
      @(negedge clk);
    end
    check("midrst_dropped", out_cnt - base, 0);
    sb_en = 1'b0;
    run_vec(vecs[1], "midrst_next");

    // Throughput with valid and ready held high
    sb_en  = 1'b1;
    base   = out_cnt;
    stalls = 0;
    c0     = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_0     = pick_operand();
      in_1     = pick_operand();
      carry_in = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(negedge clk);
      if (i == 0) c0 = cyc;
      if (!in_ready) stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain("tp");
    check("tp_stalls", stalls, 0);
    check("tp_out_count", out_cnt - base, 200);
    check("tp_span", last_out_cyc - c0, 201);

    // Random streaming with random valid and ready
    base  = out_cnt;
    acc   = 0;
    guard = 0;
    pend  = 1'b0;
    @(posedge clk);
    #1;
    while (acc < 10000 && guard < 80000) begin
      if (!pend) begin
        in_0     = pick_operand();
        in_1     = pick_operand();
        carry_in = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      pend = in_valid && !in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rnd_accepted", acc, 10000);
    drain("rnd");
    check("rnd_out_count", out_cnt - base, 10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipelined_addsub.md
CLA_PIPELINED_ADDSUB -- requirements
Module: cla_pipelined_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal values are multiples of 4, from 8 to 64.
REQ-002 SHALL have parameter GROUP, fixed at 4: bits per carry-lookahead group; NGROUP = WIDTH/GROUP.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: the operand set is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: the block accepts operands this cycle.
REQ-007 SHALL have port in_0, input, WIDTH: operand A.
REQ-008 SHALL have port in_1, input, WIDTH: operand B.
REQ-009 SHALL have port carry_in, input, 1: carry into bit 0; used only in add mode.
REQ-010 SHALL have port sub, input, 1: 0 = A+B+carry_in; 1 = A-B.
REQ-011 SHALL have port out_valid, output, 1: the result set is valid.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-013 SHALL have port result, output, WIDTH: sum or difference, modulo 2^WIDTH.
REQ-014 SHALL have port carry_out, output, 1: carry out of the MSB; in sub mode it is the inverted borrow.
REQ-015 SHALL have port overflow, output, 1: two's-complement signed overflow.
REQ-016 SHALL have port zero, output, 1: result == 0.

Function
REQ-017 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 SHALL in sub mode use operand ~in_1 and an effective carry-in of 1; carry_in is ignored.
REQ-019 SHALL have two pipeline stages, S1 and S2, each with a valid bit.
- S1 registers A, B_eff, c0, and per-group P, G and the 4-bit propagate/generate vectors.
- S2 registers the lookahead group carries, result and flags.
REQ-020 SHALL compute group carries by lookahead: C[i+1] = G[i] | (P[i] & C[i]), flattened per group, with no ripple across groups.
REQ-021 SHALL have a latency of exactly 2 cycles from input acceptance to out_valid when out_ready is held at 1.
REQ-022 SHALL sustain a throughput of one operation per cycle while out_ready = 1.
REQ-023 SHALL use the following advance rules:
- s2_adv = !s2_valid | out_ready.
- s1_adv = !s1_valid | s2_adv.
- in_ready = s1_adv.
- in_ready is combinational from out_ready; there are no other combinational in-to-out paths.
REQ-024 SHALL hold result and all flags stable while out_valid && !out_ready.
REQ-025 SHALL hold S1 contents while S1 is stalled and no new input is accepted.
REQ-026 SHALL handle a simultaneous S2 drain and S1 refill in the same cycle with no bubble and no loss of data.
REQ-027 SHALL compute overflow = c[WIDTH-1] ^ c[WIDTH], i.e. the carry into the MSB XOR the carry out of the MSB.
REQ-028 SHALL update result and flags only when S2 loads; a stage that is not valid SHALL NOT alter its outputs.

Reset
REQ-029 SHALL on reset clear s1_valid and s2_valid, force out_valid = 0, and force result = 0, carry_out = 0, overflow = 0, zero = 0.
REQ-030 SHALL keep in_ready = 1 during reset and in the cycle after it.
REQ-031 SHALL discard any operation accepted before reset that is in flight when reset is asserted mid-operation; no stale out_valid SHALL follow reset deassertion.
REQ-032 SHALL let reset take priority over any simultaneous handshake.

Structure
REQ-033 SHALL place GROUP and the WIDTH legality check in a shared package/header, cla_pkg.
REQ-034 SHALL instantiate one sub-module, cla_group_4bit, NGROUP times: it produces group P and G and the 4-bit sum given a group carry-in.
REQ-035 SHALL keep the lookahead carry unit a generate loop inside cla_pipelined_addsub.

Verification (WIDTH=16)
REQ-036 SHALL cover add with carry: A=0xFFFF, B=0x0001, carry_in=0, sub=0 -> after 2 cycles result=0x0000, carry_out=1, zero=1, overflow=0.
REQ-037 SHALL cover signed overflow: A=0x7FFF, B=0x0001, sub=0 -> result=0x8000, overflow=1, carry_out=0.
REQ-038 SHALL cover subtraction: A=0x0005, B=0x0007, sub=1, carry_in=1 -> result=0xFFFE, carry_out=0, overflow=0; and A=0x8000, B=0x0001, sub=1 -> result=0x7FFF, overflow=1.
REQ-039 SHALL cover back-pressure: stream 4 ops with out_ready=0 for cycles 2-5 -> in_ready falls once both stages are full; all 4 results arrive in order, none dropped or duplicated.
REQ-040 SHALL cover reset mid-flight: accept an op, assert reset the next cycle -> out_valid stays 0; the first post-reset op appears 2 cycles after acceptance.
REQ-041 SHALL cover random streaming: 10k random ops with random valid/ready -> every result, carry_out, overflow and zero matches a behavioural model; throughput is 1/cycle when both valid and ready are constantly 1.
